// File: rtl/core_pkg.sv
// Shared constants for the RV32I core: datapath widths and writeback result-select encodings.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage : core_pkg

// File: rtl/wb_result_mux.sv
// Writeback result select: ALU result, load data or link address; the reserved encoding yields 0.
module wb_result_mux
    import core_pkg::*;
#(
    parameter int W = core_pkg::XLEN
) (
    input  logic [W-1:0] alu_result_i,
    input  logic [W-1:0] read_data_i,
    input  logic [W-1:0] pc_plus4_i,
    input  logic [1:0]   result_src_i,
    output logic [W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (result_src_i)
            RES_ALU: result_o = alu_result_i;
            RES_MEM: result_o = read_data_i;
            RES_PC4: result_o = pc_plus4_i;
            default: result_o = '0;
        endcase
    end

endmodule : wb_result_mux

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32-entry register file with write-through bypass on both
// decode read ports, and a wrapping counter of committed (non-x0) writes.
module writeback_regfile
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       ALUResultW,
    input  logic [XLEN-1:0]       ReadDataW,
    input  logic [XLEN-1:0]       PCPlus4W,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [1:0]            ResultSrcW,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] A1,
    input  logic [REG_ADDR_W-1:0] A2,
    output logic [XLEN-1:0]       RD1,
    output logic [XLEN-1:0]       RD2,
    output logic [XLEN-1:0]       ResultW,
    output logic [CNT_W-1:0]      WriteCount
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic [NREGS-1:0]           reg_we;
    logic [CNT_W-1:0]           count_q;
    logic [CNT_W-1:0]           count_d;
    logic                       commit;
    logic                       bypass1;
    logic                       bypass2;

    wb_result_mux #(
        .W (XLEN)
    ) u_result_mux (
        .alu_result_i (ALUResultW),
        .read_data_i  (ReadDataW),
        .pc_plus4_i   (PCPlus4W),
        .result_src_i (ResultSrcW),
        .result_o     (ResultW)
    );

    // Reset takes priority, so a write presented alongside it neither commits nor bypasses.
    assign commit = RegWriteW && (RdW != '0) && !rst;

    // x0 is never written: its enable stays low and its next state is always zero.
    assign reg_we[0] = 1'b0;
    assign regs_d[0] = '0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg_next
            assign reg_we[gi] = commit && (RdW == REG_ADDR_W'(gi));
            assign regs_d[gi] = reg_we[gi] ? ResultW : regs_q[gi];
        end
    endgenerate

    assign count_d = commit ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    assign bypass1 = commit && (RdW == A1);
    assign bypass2 = commit && (RdW == A2);

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != '0) begin
            RD1 = bypass1 ? ResultW : regs_q[A1];
        end
        if (A2 != '0) begin
            RD2 = bypass2 ? ResultW : regs_q[A2];
        end
    end

    assign WriteCount = count_q;

endmodule : writeback_regfile
